tcu_noc_burst_packer: RTL

- Upstream feeder of the TCU NoC output FIFO.
- Turns one transfer command plus a stream of payload words into NoC flits:
  - a single non-burst flit, or
  - a burst: one header flit followed by N payload flits.
- Drives the flit-level wrreq/stall interface that the FIFO's slave side consumes.
- Burst bit is set on every flit of a burst except the last, which is how the FIFO detects burst completion.

---
 rtl/tcu_noc_burst_packer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tcu_noc_burst_packer.sv
// Packs a transfer command plus payload words into single or burst NoC flits; TCU_NOC_PACKER_LENCHK_EN adds a length check.
// Latency: command or payload word accepted at t gives its flit (noc_wrreq_o) at t+1, with no bubbles between flits.
// Backpressure: noc_stall_i freezes the output register; cmd_ready_o/dat_ready_o drop while it cannot reload.
module tcu_noc_burst_packer #(
    parameter int MAX_BURST_LEN   = 16,
    parameter int CNT_SIZE        = $clog2(MAX_BURST_LEN + 1),
    parameter int NOC_CHIPID_SIZE = 8,
    parameter int NOC_MODID_SIZE  = 8,
    parameter int NOC_MODE_SIZE   = 4,
    parameter int NOC_ADDR_SIZE   = 32,
    parameter int NOC_DATA_SIZE   = 64,
    parameter int NOC_BSEL_SIZE   = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NOC_CHIPID_SIZE-1:0] home_chipid_i,
    input  logic [NOC_MODID_SIZE-1:0]  home_modid_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [NOC_CHIPID_SIZE-1:0] cmd_trg_chipid_i,
    input  logic [NOC_MODID_SIZE-1:0]  cmd_trg_modid_i,
    input  logic [NOC_MODE_SIZE-1:0]   cmd_mode_i,
    input  logic [NOC_ADDR_SIZE-1:0]   cmd_addr_i,
    input  logic [7:0]                 cmd_len_i,
    input  logic [NOC_DATA_SIZE-1:0]   cmd_data_i,
    input  logic [NOC_BSEL_SIZE-1:0]   cmd_bsel_i,
    input  logic                       dat_valid_i,
    output logic                       dat_ready_o,
    input  logic [NOC_DATA_SIZE-1:0]   dat_data0_i,
    input  logic [NOC_DATA_SIZE-1:0]   dat_data1_i,
    input  logic [NOC_BSEL_SIZE-1:0]   dat_bsel_i,
    output logic                       noc_wrreq_o,
    output logic                       noc_burst_o,
    output logic [NOC_BSEL_SIZE-1:0]   noc_bsel_o,
    output logic [NOC_CHIPID_SIZE-1:0] noc_src_chipid_o,
    output logic [NOC_MODID_SIZE-1:0]  noc_src_modid_o,
    output logic [NOC_CHIPID_SIZE-1:0] noc_trg_chipid_o,
    output logic [NOC_MODID_SIZE-1:0]  noc_trg_modid_o,
    output logic [NOC_MODE_SIZE-1:0]   noc_mode_o,
    output logic [NOC_ADDR_SIZE-1:0]   noc_addr_o,
    output logic [NOC_DATA_SIZE-1:0]   noc_data0_o,
    output logic [NOC_DATA_SIZE-1:0]   noc_data1_o,
    input  logic                       noc_stall_i,
    output logic                       busy_o,
    output logic                       err_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, DATA = 2'd2} state_t;

    state_t                     r_state;
    logic [CNT_SIZE-1:0]        r_cnt;
    logic                       r_vld;
    logic                       r_burst;
    logic [NOC_BSEL_SIZE-1:0]   r_bsel;
    logic [NOC_CHIPID_SIZE-1:0] r_src_chipid;
    logic [NOC_MODID_SIZE-1:0]  r_src_modid;
    logic [NOC_CHIPID_SIZE-1:0] r_trg_chipid;
    logic [NOC_MODID_SIZE-1:0]  r_trg_modid;
    logic [NOC_MODE_SIZE-1:0]   r_mode;
    logic [NOC_ADDR_SIZE-1:0]   r_addr;
    logic [NOC_DATA_SIZE-1:0]   r_data0;
    logic [NOC_DATA_SIZE-1:0]   r_data1;

    logic                w_xfer;
    logic                w_oreg_free;
    logic                w_cmd_acc;
    logic                w_dat_acc;
    logic                w_len_bad;
    logic [CNT_SIZE-1:0] w_len;

    // The output register may reload in the same cycle its flit leaves, so throughput is one flit per cycle.
    assign w_xfer      = r_vld && !noc_stall_i;
    assign w_oreg_free = !r_vld || w_xfer;
    assign cmd_ready_o = !reset_i && (r_state == IDLE) && w_oreg_free;
    assign dat_ready_o = (r_state == DATA) && w_oreg_free;
    assign w_cmd_acc   = cmd_valid_i && cmd_ready_o;
    assign w_dat_acc   = dat_valid_i && dat_ready_o;
    assign w_len       = CNT_SIZE'(cmd_len_i);

`ifdef TCU_NOC_PACKER_LENCHK_EN
    logic r_err;

    assign w_len_bad = (32'(cmd_len_i) > 32'(MAX_BURST_LEN));

    // High exactly during the single HEAD cycle that follows a rejected command.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && w_cmd_acc && w_len_bad;
        end
    end

    assign err_o = r_err;
`else
    assign w_len_bad = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_vld        <= 1'b0;
            r_burst      <= 1'b0;
            r_bsel       <= '0;
            r_src_chipid <= '0;
            r_src_modid  <= '0;
            r_trg_chipid <= '0;
            r_trg_modid  <= '0;
            r_mode       <= '0;
            r_addr       <= '0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            if (w_xfer) begin
                r_vld <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_cmd_acc) begin
                        if (w_len_bad) begin
                            r_state <= HEAD;
                        end else begin
                            r_vld        <= 1'b1;
                            r_burst      <= (w_len != '0);
                            r_bsel       <= cmd_bsel_i;
                            r_src_chipid <= home_chipid_i;
                            r_src_modid  <= home_modid_i;
                            r_trg_chipid <= cmd_trg_chipid_i;
                            r_trg_modid  <= cmd_trg_modid_i;
                            r_mode       <= cmd_mode_i;
                            r_addr       <= cmd_addr_i;
                            r_data0      <= (w_len == '0) ? cmd_data_i : NOC_DATA_SIZE'(w_len);
                            r_data1      <= '0;
                            r_cnt        <= w_len;
                            if (w_len != '0) begin
                                r_state <= DATA;
                            end
                        end
                    end
                end
                HEAD: begin
                    r_state <= IDLE;
                end
                DATA: begin
                    if (w_dat_acc) begin
                        // The final payload flit clears burst so the FIFO sees the end of the burst.
                        r_vld        <= 1'b1;
                        r_burst      <= (r_cnt > CNT_SIZE'(1));
                        r_bsel       <= dat_bsel_i;
                        r_src_chipid <= '0;
                        r_src_modid  <= '0;
                        r_trg_chipid <= '0;
                        r_trg_modid  <= '0;
                        r_mode       <= '0;
                        r_addr       <= '0;
                        r_data0      <= dat_data0_i;
                        r_data1      <= dat_data1_i;
                        r_cnt        <= r_cnt - CNT_SIZE'(1);
                        if (r_cnt == CNT_SIZE'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign noc_wrreq_o      = r_vld;
    assign noc_burst_o      = r_burst;
    assign noc_bsel_o       = r_bsel;
    assign noc_src_chipid_o = r_src_chipid;
    assign noc_src_modid_o  = r_src_modid;
    assign noc_trg_chipid_o = r_trg_chipid;
    assign noc_trg_modid_o  = r_trg_modid;
    assign noc_mode_o       = r_mode;
    assign noc_addr_o       = r_addr;
    assign noc_data0_o      = r_data0;
    assign noc_data1_o      = r_data1;
    assign busy_o           = (r_state != IDLE) || r_vld;

endmodule
